// File: rtl/baud_gen_frac_if.sv
// Rate-configuration handshake for baud_gen_frac.
// The master offers a phase increment; the slave accepts it with cfg_ready.
interface baud_gen_frac_if #(
    parameter int ACC_W = 24
) ();
    logic [ACC_W-1:0] cfg_inc;
    logic             cfg_valid;
    logic             cfg_ready;

    modport master (
        output cfg_inc,
        output cfg_valid,
        input  cfg_ready
    );

    modport slave (
        input  cfg_inc,
        input  cfg_valid,
        output cfg_ready
    );
endinterface

// File: rtl/baud_gen_frac.sv
// Fractional-N baud generator: phase accumulator giving os_tick and baud_tick.
// Define BAUD_GEN_FRAC_STATUS_EN to add the baud_cnt status counter port.
module baud_gen_frac #(
    parameter int ACC_W      = 24,
    parameter int OVERSAMPLE = 16,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    baud_gen_frac_if.slave                cfg,
    input  logic                          resync,
    output logic                          os_tick,
    output logic                          baud_tick,
`ifdef BAUD_GEN_FRAC_STATUS_EN
    output logic [CNT_W-1:0]              baud_cnt,
`endif
    output logic [$clog2(OVERSAMPLE)-1:0] os_phase
);

    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2);

    if (OVERSAMPLE < 4 || OVERSAMPLE > 64 ||
        (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_os
        $error("OVERSAMPLE must be a power of two in 4..64");
    end
    if (ACC_W < 2 || CNT_W < 1) begin : g_bad_width
        $error("ACC_W must be >= 2 and CNT_W >= 1");
    end

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] inc_q, inc_d;
    logic [ACC_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
    logic             os_tick_q, os_tick_d;
    logic             baud_tick_q, baud_tick_d;

    logic [ACC_W:0]   sum;
    logic             carry;
    logic             bit_end;
    logic             inc_zero;

    always_comb begin
        sum         = {1'b0, acc_q} + {1'b0, inc_q};
        carry       = sum[ACC_W];
        inc_zero    = (inc_q == '0);
        bit_end     = 1'b0;
        acc_d       = acc_q;
        os_cnt_d    = os_cnt_q;
        os_tick_d   = 1'b0;
        baud_tick_d = 1'b0;
        inc_d       = inc_q;
        pend_d      = pend_q;
        pend_vld_d  = pend_vld_q;

        // Resync wins over accumulation and suppresses any carry this edge.
        if (resync) begin
            acc_d    = '0;
            os_cnt_d = OS_HALF;
        end else if (enable) begin
            acc_d     = sum[ACC_W-1:0];
            os_tick_d = carry;
            if (carry) begin
                os_cnt_d = os_cnt_q + OS_W'(1);
            end
            bit_end     = carry & (os_cnt_q == OS_LAST);
            baud_tick_d = bit_end;
        end

        // A rate change lands only where it cannot shorten a bit in flight.
        if (pend_vld_q) begin
            if (bit_end | ~enable | inc_zero) begin
                inc_d      = pend_q;
                pend_vld_d = 1'b0;
            end
        end else if (cfg.cfg_valid) begin
            pend_d     = cfg.cfg_inc;
            pend_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q       <= '0;
            inc_q       <= '0;
            pend_q      <= '0;
            pend_vld_q  <= 1'b0;
            os_cnt_q    <= '0;
            os_tick_q   <= 1'b0;
            baud_tick_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            inc_q       <= inc_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
            os_cnt_q    <= os_cnt_d;
            os_tick_q   <= os_tick_d;
            baud_tick_q <= baud_tick_d;
        end
    end

`ifdef BAUD_GEN_FRAC_STATUS_EN
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;

    always_comb begin
        baud_cnt_d = baud_cnt_q + CNT_W'(baud_tick_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_cnt_q <= '0;
        end else begin
            baud_cnt_q <= baud_cnt_d;
        end
    end

    assign baud_cnt = baud_cnt_q;
`endif

    assign cfg.cfg_ready = ~pend_vld_q;
    assign os_tick       = os_tick_q;
    assign baud_tick     = baud_tick_q;
    assign os_phase      = os_cnt_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Self-checking bench for baud_gen_frac: directed table, corner sequences
// and randomized traffic against an absolute-phase reference model.
module tb_baud_gen_frac;

    localparam int ACC_W = 24;
    localparam int OS    = 16;
    localparam int CNT_W = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       resync = 1'b0;
    logic       os_tick;
    logic       baud_tick;
    logic [3:0] os_phase;
`ifdef BAUD_GEN_FRAC_STATUS_EN
    logic [CNT_W-1:0] baud_cnt;
`endif

    baud_gen_frac_if #(.ACC_W(ACC_W)) cfg ();

    baud_gen_frac #(
        .ACC_W(ACC_W),
        .OVERSAMPLE(OS),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .cfg(cfg),
        .resync(resync),
        .os_tick(os_tick),
        .baud_tick(baud_tick),
`ifdef BAUD_GEN_FRAC_STATUS_EN
        .baud_cnt(baud_cnt),
`endif
        .os_phase(os_phase)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: unbounded absolute phase; an os tick is every
    // crossing of a multiple of 2^ACC_W, a bit is every OS-th such tick.
    logic [63:0]      m_phase;
    logic [ACC_W-1:0] m_inc;
    logic [ACC_W-1:0] m_pend;
    bit               m_pv;
    int               m_os;
    bit               m_ot;
    bit               m_bt;
    int               m_bcnt;

    function automatic void model_reset();
        m_phase = '0;
        m_inc   = '0;
        m_pend  = '0;
        m_pv    = 1'b0;
        m_os    = 0;
        m_ot    = 1'b0;
        m_bt    = 1'b0;
        m_bcnt  = 0;
    endfunction

    function automatic void model_edge(bit en, bit rs, bit cv,
                                       logic [ACC_W-1:0] ci);
        logic [63:0]      np;
        logic [ACC_W-1:0] old_inc;
        bit               rdy;
        old_inc = m_inc;
        rdy     = !m_pv;
        m_ot    = 1'b0;
        m_bt    = 1'b0;
        if (rs) begin
            m_phase = '0;
            m_os    = OS / 2;
        end else if (en) begin
            np = m_phase + 64'(m_inc);
            if ((np >> ACC_W) != (m_phase >> ACC_W)) begin
                m_ot = 1'b1;
                m_bt = (m_os == OS - 1);
                m_os = (m_os + 1) % OS;
            end
            m_phase = np;
        end
        if (m_pv) begin
            if (m_bt || !en || old_inc == 0) begin
                m_inc = m_pend;
                m_pv  = 1'b0;
            end
        end else if (cv && rdy) begin
            m_pend = ci;
            m_pv   = 1'b1;
        end
        if (m_bt) m_bcnt = (m_bcnt + 1) % (1 << CNT_W);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return {25'd0, cfg.cfg_ready, os_tick, baud_tick, os_phase};
    endfunction

    task automatic check_model(string name);
        check(name, dut_vec(),
              {25'd0, !m_pv, m_ot, m_bt, 4'(m_os)});
`ifdef BAUD_GEN_FRAC_STATUS_EN
        check({name, "_cnt"}, 32'(baud_cnt), 32'(m_bcnt));
`endif
    endtask

    task automatic step(bit en, bit rs, bit cv, logic [ACC_W-1:0] ci);
        enable        = en;
        resync        = rs;
        cfg.cfg_valid = cv;
        cfg.cfg_inc   = ci;
        @(posedge clk);
        model_edge(en, rs, cv, ci);
        #1;
        check_model("cyc");
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset         = 1'b1;
        enable        = 1'b0;
        resync        = 1'b0;
        cfg.cfg_valid = 1'b0;
        cfg.cfg_inc   = '0;
        #1;
        model_reset();
        check("reset_vals", dut_vec(), 32'h40);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load(logic [ACC_W-1:0] inc);
        step(1'b1, 1'b0, 1'b1, inc);
        step(1'b1, 1'b0, 1'b0, '0);
    endtask

    // Waits (bounded) for a fresh os_tick landing on the given phase.
    task automatic wait_phase(int ph, string name);
        bit found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            step(1'b1, 1'b0, 1'b0, '0);
            if (os_tick && os_phase == 4'(ph)) found = 1'b1;
        end
        check(name, 32'(found), 32'd1);
    endtask

    typedef struct {
        logic [ACC_W-1:0] inc;
        int               n;
        int               exp_os;
        int               exp_bt;
        int               exp_ph;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int n_os;
        int n_bt;
        int gap;
        int bad;
        int t0;
        bit found;

        cfg.cfg_valid = 1'b0;
        cfg.cfg_inc   = '0;
        model_reset();

        vecs[0] = '{24'h100000,  512,  32,  2,  0};
        vecs[1] = '{24'h600000,  128,  48,  3,  0};
        vecs[2] = '{24'h000000, 1000,   0,  0,  0};
        vecs[3] = '{24'hFFFFFF,  256, 255, 15, 15};
        vecs[4] = '{24'h0C0000,  640,  30,  1, 14};

        // Directed rates: tick counts follow floor(n * inc / 2^ACC_W).
        foreach (vecs[v]) begin
            do_reset();
            load(vecs[v].inc);
            n_os = 0;
            n_bt = 0;
            for (int i = 0; i < vecs[v].n; i++) begin
                step(1'b1, 1'b0, 1'b0, '0);
                n_os += int'(os_tick);
                n_bt += int'(baud_tick);
            end
            check($sformatf("tbl%0d_os", v), 32'(n_os), 32'(vecs[v].exp_os));
            check($sformatf("tbl%0d_bt", v), 32'(n_bt), 32'(vecs[v].exp_bt));
            check($sformatf("tbl%0d_ph", v), 32'(os_phase),
                  32'(vecs[v].exp_ph));
        end

        // Zero increment: silent, then a new rate applies immediately.
        do_reset();
        n_os = 0;
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, 1'b0, 1'b0, '0);
            n_os += int'(os_tick) + int'(baud_tick);
        end
        check("zero_noticks", 32'(n_os), 32'd0);
        step(1'b1, 1'b0, 1'b1, 24'h100000);
        check("zero_rdy_low", 32'(cfg.cfg_ready), 32'd0);
        step(1'b1, 1'b0, 1'b0, '0);
        check("zero_rdy_back", 32'(cfg.cfg_ready), 32'd1);

        // Rate change mid-bit: held off until the bit boundary.
        wait_phase(5, "rc_find_ph5");
        step(1'b1, 1'b0, 1'b1, 24'h200000);
        bad   = 0;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            step(1'b1, 1'b0, 1'b0, '0);
            if (baud_tick) found = 1'b1;
            else if (cfg.cfg_ready) bad++;
        end
        check("rc_bit_seen", 32'(found), 32'd1);
        check("rc_early_rdy", 32'(bad), 32'd0);
        check("rc_rdy_at_bit", 32'(cfg.cfg_ready), 32'd1);
        for (int k = 0; k < 2; k++) begin
            gap   = 0;
            found = 1'b0;
            for (int i = 0; i < 40 && !found; i++) begin
                step(1'b1, 1'b0, 1'b0, '0);
                gap++;
                if (os_tick) found = 1'b1;
            end
            check($sformatf("rc_period%0d", k), 32'(gap), 32'd8);
        end

        // Resync while running: mid-bit, then half a bit to the edge.
        do_reset();
        load(24'h100000);
        wait_phase(3, "rs_find_ph3");
        step(1'b1, 1'b1, 1'b0, '0);
        check("rs_phase", 32'(os_phase), 32'd8);
        check("rs_ticks", 32'({os_tick, baud_tick}), 32'd0);
        t0    = 0;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            step(1'b1, 1'b0, 1'b0, '0);
            t0++;
            if (baud_tick) found = 1'b1;
        end
        check("rs_bit_dist", 32'(t0), 32'd128);

        // Resync while disabled: counters hold at mid-bit.
        wait_phase(3, "rsd_find_ph3");
        step(1'b0, 1'b1, 1'b0, '0);
        check("rsd_phase", 32'(os_phase), 32'd8);
        n_os = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0, '0);
            n_os += int'(os_tick) + int'(baud_tick);
        end
        check("rsd_hold_ph", 32'(os_phase), 32'd8);
        check("rsd_noticks", 32'(n_os), 32'd0);

        // Asynchronous reset with a config pending at phase 7.
        wait_phase(7, "rst_find_ph7");
        step(1'b1, 1'b0, 1'b1, 24'h200000);
        check("rst_pending", 32'({cfg.cfg_ready, os_phase}), 32'h07);
        #2;
        reset = 1'b1;
        #1;
        check("rst_async", dut_vec(), 32'h40);
`ifdef BAUD_GEN_FRAC_STATUS_EN
        check("rst_cnt", 32'(baud_cnt), 32'd0);
`endif
        model_reset();
        @(negedge clk);
        cfg.cfg_valid = 1'b0;
        reset = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            bit               en;
            bit               rs;
            bit               cv;
            logic [ACC_W-1:0] ci;
            en = ($urandom % 8) != 0;
            rs = ($urandom % 64) == 0;
            cv = ($urandom % 4) == 0;
            case ($urandom % 4)
                0: ci = '0;
                1: ci = ACC_W'($urandom);
                2: ci = ACC_W'($urandom_range(1, 24'h0FFFFF));
                default: ci = 24'hFFFFFF - ACC_W'($urandom % 16);
            endcase
            step(en, rs, cv, ci);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
